// File: rtl/imsic_port_arbiter.sv
// rtl/imsic_port_arbiter.sv - round-robin arbiter of per-hart IMSIC accesses onto one IMSIC port
// Optional IMSIC_ARB_MPRIO_EN: M-mode requesters win arbitration over lower privilege levels.
module imsic_port_arbiter #(
   parameter int unsigned NrHarts      = 4,
   parameter int unsigned XLen         = 64,
   parameter int unsigned VgeinW       = 7,
   parameter int unsigned ImsicLatency = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NrHarts-1:0]             hart_req_valid_i,
   output logic [NrHarts-1:0]             hart_req_ready_o,
   input  logic [NrHarts-1:0][1:0]        hart_priv_lvl_i,
   input  logic [NrHarts-1:0][VgeinW-1:0] hart_vgein_i,
   input  logic [NrHarts-1:0][31:0]       hart_addr_i,
   input  logic [NrHarts-1:0][XLen-1:0]   hart_data_i,
   input  logic [NrHarts-1:0]             hart_we_i,
   input  logic [NrHarts-1:0]             hart_claim_i,
   output logic [NrHarts-1:0]             hart_rsp_valid_o,
   output logic [XLen-1:0]                hart_rsp_data_o,
   output logic                           hart_rsp_exception_o,
   output logic                           imsic_req_o,
   output logic [1:0]                     imsic_priv_lvl_o,
   output logic [VgeinW-1:0]              imsic_vgein_o,
   output logic [31:0]                    imsic_addr_o,
   output logic [XLen-1:0]                imsic_data_o,
   output logic                           imsic_we_o,
   output logic                           imsic_claim_o,
   input  logic [XLen-1:0]                imsic_data_i,
   input  logic                           imsic_exception_i
);

   localparam int unsigned IdxW = (NrHarts > 1) ? $clog2(NrHarts) : 1;
   localparam int unsigned CntW = (ImsicLatency > 1) ? $clog2(ImsicLatency) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   rr_ptr_q;
   logic [IdxW-1:0]   owner_q;
   logic [CntW-1:0]   cnt_q;
   logic [NrHarts-1:0] cand;
   logic              found;
   logic [IdxW-1:0]   winner;
   logic [IdxW:0]     sum;
   logic [IdxW-1:0]   idx;

`ifdef IMSIC_ARB_MPRIO_EN
   logic [NrHarts-1:0] mmode;
   for (genvar g = 0; g < NrHarts; g++) begin : gen_mmode
      assign mmode[g] = hart_req_valid_i[g] && (hart_priv_lvl_i[g] == 2'b11);
   end
`endif

   // Search starts at rr_ptr_q and wraps; first candidate found wins.
   always_comb begin
`ifdef IMSIC_ARB_MPRIO_EN
      cand = (|mmode) ? mmode : hart_req_valid_i;
`else
      cand = hart_req_valid_i;
`endif
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      idx    = '0;
      for (int unsigned i = 0; i < NrHarts; i++) begin
         sum = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
         if (sum >= (IdxW+1)'(NrHarts)) sum = sum - (IdxW+1)'(NrHarts);
         idx = sum[IdxW-1:0];
         if (!found && cand[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      hart_req_ready_o = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               hart_req_ready_o = NrHarts'(1) << winner;
               state_d          = ISSUE;
            end
         end
         ISSUE:   state_d = WAIT;
         WAIT:    if (cnt_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q             <= '0;
         owner_q              <= '0;
         cnt_q                <= '0;
         hart_rsp_valid_o     <= '0;
         hart_rsp_data_o      <= '0;
         hart_rsp_exception_o <= 1'b0;
         imsic_req_o          <= 1'b0;
         imsic_priv_lvl_o     <= '0;
         imsic_vgein_o        <= '0;
         imsic_addr_o         <= '0;
         imsic_data_o         <= '0;
         imsic_we_o           <= 1'b0;
         imsic_claim_o        <= 1'b0;
      end else begin
         // Strobes last exactly one cycle; field outputs hold their latched values.
         imsic_req_o      <= 1'b0;
         imsic_we_o       <= 1'b0;
         imsic_claim_o    <= 1'b0;
         hart_rsp_valid_o <= '0;
         case (state_q)
            IDLE: begin
               if (found) begin
                  owner_q          <= winner;
                  rr_ptr_q         <= (winner == IdxW'(NrHarts-1)) ? '0 : winner + 1'b1;
                  imsic_req_o      <= 1'b1;
                  imsic_priv_lvl_o <= hart_priv_lvl_i[winner];
                  imsic_vgein_o    <= hart_vgein_i[winner];
                  imsic_addr_o     <= hart_addr_i[winner];
                  imsic_data_o     <= hart_data_i[winner];
                  imsic_we_o       <= hart_we_i[winner];
                  imsic_claim_o    <= hart_claim_i[winner];
               end
            end
            ISSUE: cnt_q <= CntW'(ImsicLatency - 1);
            WAIT: begin
               if (cnt_q == '0) begin
                  hart_rsp_data_o      <= imsic_data_i;
                  hart_rsp_exception_o <= imsic_exception_i;
                  hart_rsp_valid_o     <= NrHarts'(1) << owner_q;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imsic_port_arbiter.sv
// tb/tb_imsic_port_arbiter.sv - directed self-checking bench for imsic_port_arbiter
module tb_imsic_port_arbiter;

   localparam int NH = 4;
   localparam int XL = 64;
   localparam int VW = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst_ni;
   logic [NH-1:0]         valid, we, claim;
   logic [NH-1:0][1:0]    priv;
   logic [NH-1:0][VW-1:0] vgein;
   logic [NH-1:0][31:0]   addr;
   logic [NH-1:0][XL-1:0] wdata;
   logic [XL-1:0]         imsic_rdata;
   logic                  imsic_exc;

   logic [NH-1:0] ready, rsp_valid;
   logic [XL-1:0] rsp_data, i_data;
   logic          rsp_exc, i_req, i_we, i_claim;
   logic [1:0]    i_priv;
   logic [VW-1:0] i_vgein;
   logic [31:0]   i_addr;

   logic [NH-1:0] ready4, rsp_valid4;
   logic [XL-1:0] rsp_data4, i_data4;
   logic          rsp_exc4, i_req4, i_we4, i_claim4;
   logic [1:0]    i_priv4;
   logic [VW-1:0] i_vgein4;
   logic [31:0]   i_addr4;

   imsic_port_arbiter #(.NrHarts(NH), .XLen(XL), .VgeinW(VW), .ImsicLatency(1)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .hart_req_valid_i(valid), .hart_req_ready_o(ready),
      .hart_priv_lvl_i(priv), .hart_vgein_i(vgein), .hart_addr_i(addr),
      .hart_data_i(wdata), .hart_we_i(we), .hart_claim_i(claim),
      .hart_rsp_valid_o(rsp_valid), .hart_rsp_data_o(rsp_data), .hart_rsp_exception_o(rsp_exc),
      .imsic_req_o(i_req), .imsic_priv_lvl_o(i_priv), .imsic_vgein_o(i_vgein),
      .imsic_addr_o(i_addr), .imsic_data_o(i_data), .imsic_we_o(i_we), .imsic_claim_o(i_claim),
      .imsic_data_i(imsic_rdata), .imsic_exception_i(imsic_exc)
   );

   imsic_port_arbiter #(.NrHarts(NH), .XLen(XL), .VgeinW(VW), .ImsicLatency(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_ni),
      .hart_req_valid_i(valid), .hart_req_ready_o(ready4),
      .hart_priv_lvl_i(priv), .hart_vgein_i(vgein), .hart_addr_i(addr),
      .hart_data_i(wdata), .hart_we_i(we), .hart_claim_i(claim),
      .hart_rsp_valid_o(rsp_valid4), .hart_rsp_data_o(rsp_data4), .hart_rsp_exception_o(rsp_exc4),
      .imsic_req_o(i_req4), .imsic_priv_lvl_o(i_priv4), .imsic_vgein_o(i_vgein4),
      .imsic_addr_o(i_addr4), .imsic_data_o(i_data4), .imsic_we_o(i_we4), .imsic_claim_o(i_claim4),
      .imsic_data_i(imsic_rdata), .imsic_exception_i(imsic_exc)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int gnt_hart[16];
   int gnt_win[16];
   int n_gnt;
   int cnt;
   logic [NH-1:0] rdy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NH-1:0] v);
      onehot_idx = 99;
      if ($countones(v) == 1)
         for (int i = 0; i < NH; i++) if (v[i]) onehot_idx = i;
   endfunction

   task automatic clear_inputs();
      valid = '0; we = '0; claim = '0; priv = '0; vgein = '0; addr = '0; wdata = '0;
      imsic_rdata = 64'hBAD; imsic_exc = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
   endtask

   // Called at a negedge; returns 1ns into the issue cycle (T+1).
   task automatic req(input logic [1:0] h, input logic w, input logic c, input logic [63:0] d,
                      input logic [VW-1:0] vg, input logic [1:0] p, input logic [31:0] a,
                      output logic [NH-1:0] rdy_at_t);
      bit ok;
      ok = 1'b0;
      rdy_at_t = '0;
      we[h] = w; claim[h] = c; wdata[h] = d; vgein[h] = vg; priv[h] = p; addr[h] = a; valid[h] = 1'b1;
      for (int k = 0; k < 20 && !ok; k++) begin
         #1;
         if (ready[h]) begin
            ok = 1'b1;
            rdy_at_t = ready;
         end else begin
            @(negedge clk);
         end
      end
      check("req_accept", 64'(ok), 64'd1);
      @(negedge clk);
      valid[h] = 1'b0; we[h] = 1'b0; claim[h] = 1'b0;
      #1;
   endtask

   task automatic watch_grants(input int nwin, input bit drop);
      logic [NH-1:0] r;
      n_gnt = 0;
      for (int k = 0; k < nwin; k++) begin
         #1;
         r = ready;
         if (r != '0 && n_gnt < 16) begin
            gnt_hart[n_gnt] = onehot_idx(r);
            gnt_win[n_gnt]  = k;
            n_gnt++;
         end
         @(negedge clk);
         if (drop) valid = valid & ~r;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_ni = 1'b0;
      clear_inputs();
      #1;
      check("rst_strobes", 64'({ready, rsp_valid, i_req, i_we, i_claim}), 64'd0);
      check("rst_fields", 64'({i_priv, i_vgein, i_addr}), 64'd0);
      check("rst_idata", i_data, 64'd0);
      check("rst_rsp", 64'({rsp_exc, rsp_data}), 64'd0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;

      // Single read from hart 2
      req(2'd2, 1'b0, 1'b0, 64'd0, '0, 2'b00, 32'h70, rdy);
      check("rd_ready_at_T", 64'(rdy), 64'b0100);
      check("rd_issue_req", 64'(i_req), 64'd1);
      check("rd_issue_addr", 64'(i_addr), 64'h70);
      check("rd_issue_we", 64'(i_we), 64'd0);
      check("rd_no_ready_busy", 64'(ready), 64'd0);
      @(negedge clk);
      imsic_rdata = 64'hDEAD;
      #1;
      check("rd_req_one_cycle", 64'(i_req), 64'd0);
      @(negedge clk);
      imsic_rdata = 64'hBAD;
      #1;
      check("rd_rsp_valid", 64'(rsp_valid), 64'b0100);
      check("rd_rsp_data", rsp_data, 64'hDEAD);
      check("rd_rsp_exc", 64'(rsp_exc), 64'd0);
      @(negedge clk);
      #1;
      check("rd_rsp_pulse", 64'(rsp_valid), 64'd0);

      // Round-robin fairness with all harts valid from reset
      do_reset();
      valid = '1;
      watch_grants(18, 1'b0);
      valid = '0;
      check("rr_count", 64'(n_gnt), 64'd5);
      for (int i = 0; i < 5 && i < n_gnt; i++) begin
         check($sformatf("rr_order_%0d", i), 64'(gnt_hart[i]), 64'(i % 4));
         check($sformatf("rr_spacing_%0d", i), 64'(gnt_win[i]), 64'(4 * i));
      end

      // Write then claim forwarding from hart 1
      do_reset();
      req(2'd1, 1'b1, 1'b0, 64'h5, 7'd3, 2'b01, 32'h80, rdy);
      check("wr_req", 64'(i_req), 64'd1);
      check("wr_we", 64'(i_we), 64'd1);
      check("wr_claim", 64'(i_claim), 64'd0);
      check("wr_data", i_data, 64'h5);
      check("wr_vgein_priv", 64'({i_vgein, i_priv}), 64'({7'd3, 2'b01}));
      repeat (3) @(negedge clk);
      req(2'd1, 1'b0, 1'b1, 64'h0, 7'd3, 2'b01, 32'h80, rdy);
      check("cl_claim", 64'(i_claim), 64'd1);
      check("cl_we", 64'(i_we), 64'd0);
      @(negedge clk);
      #1;
      check("cl_claim_one_cycle", 64'(i_claim), 64'd0);
      check("cl_vgein_hold", 64'(i_vgein), 64'd3);

      // Exception return to hart 3
      do_reset();
      req(2'd3, 1'b0, 1'b0, 64'h0, '0, 2'b11, 32'h90, rdy);
      @(negedge clk);
      imsic_exc = 1'b1;
      @(negedge clk);
      imsic_exc = 1'b0;
      #1;
      check("exc_rsp_valid", 64'(rsp_valid), 64'b1000);
      check("exc_flag", 64'(rsp_exc), 64'd1);

      // Reset mid-WAIT on the latency-4 instance
      do_reset();
      req(2'd1, 1'b0, 1'b0, 64'h77, 7'd2, 2'b01, 32'h44, rdy);
      check("l4_issue_req", 64'(i_req4), 64'd1);
      check("l4_issue_addr", 64'(i_addr4), 64'h44);
      repeat (2) @(negedge clk);
      rst_ni = 1'b0;
      #1;
      check("l4_rst_strobes", 64'({ready4, rsp_valid4, i_req4, i_we4, i_claim4}), 64'd0);
      check("l4_rst_fields", 64'({i_priv4, i_vgein4, i_addr4}), 64'd0);
      check("l4_rst_idata", i_data4, 64'd0);
      check("l4_rst_rsp", 64'({rsp_exc4, rsp_data4}), 64'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (rsp_valid4 != '0) cnt++;
         @(negedge clk);
      end
      check("l4_no_rsp_after_rst", 64'(cnt), 64'd0);
      valid = '1;
      #1;
      check("l4_next_grant_hart0", 64'(ready4), 64'b0001);

      // Harts 0 (S/U priv 01) and 3 (M-mode) request together
      do_reset();
      priv[0] = 2'b01;
      priv[3] = 2'b11;
      valid   = 4'b1001;
      watch_grants(10, 1'b1);
      valid = '0;
      check("prio_count", 64'(n_gnt), 64'd2);
`ifdef IMSIC_ARB_MPRIO_EN
      check("prio_first", 64'(gnt_hart[0]), 64'd3);
      check("prio_second", 64'(gnt_hart[1]), 64'd0);
`else
      check("rr_first", 64'(gnt_hart[0]), 64'd0);
      check("rr_second", 64'(gnt_hart[1]), 64'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
